// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, FSM states and default latencies.
// The optional divide-by-zero short-cut is enabled by defining ALU_SCHED_DIV0_EN.
package alu_sched_pkg;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  localparam int DEF_SIMPLE_LAT = 1;
  localparam int DEF_MULDIV_LAT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Only div and mul use the long latency; every other code, legal or not, is simple.
  function automatic logic [3:0] op_latency(input logic [3:0] op,
                                            input logic [3:0] simple_lat,
                                            input logic [3:0] muldiv_lat);
    return ((op == OP_DIV) || (op == OP_MUL)) ? muldiv_lat : simple_lat;
  endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the preferred requester on a tie
// and moves to the other requester after every granted request.
module rr_arb2 (
  input  logic       clock,
  input  logic       clear,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = r_ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clock) begin
    if (clear)        r_ptr <= 1'b0;
    else if (advance) r_ptr <= grant[0];
  end

endmodule

// File: rtl/alu_sched.sv
// Schedules operations from two requesters onto one shared multi-cycle ALU.
// Define ALU_SCHED_DIV0_EN to answer divide-by-zero at once with rsp_err set.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int SIMPLE_LAT = DEF_SIMPLE_LAT,
  parameter int MULDIV_LAT = DEF_MULDIV_LAT
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_value1,
  output logic [31:0] alu_value2,
  output logic [3:0]  alu_select,
  input  logic [63:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers in the cycle reqN_valid & reqN_ready is high,
  // and a response transfers in the cycle rsp_valid & rsp_ready is high.
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_op, r_cnt;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic        r_id, r_err;

  logic [1:0]  w_arb_req, w_grant;
  logic        w_accept, w_gnt_id, w_div0, w_exec_done;
  logic [3:0]  w_sel_op;
  logic [31:0] w_sel_a, w_sel_b;

  // Grants are offered only from IDLE and never while clear is asserted.
  assign w_arb_req = (r_state == ST_IDLE && !clear) ? {req1_valid, req0_valid} : 2'b00;

  rr_arb2 u_arb (
    .clock   (clock),
    .clear   (clear),
    .req     (w_arb_req),
    .advance (w_accept),
    .grant   (w_grant)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_accept   = |w_grant;
  assign w_gnt_id   = w_grant[1];
  assign w_sel_op   = w_gnt_id ? req1_op : req0_op;
  assign w_sel_a    = w_gnt_id ? req1_a  : req0_a;
  assign w_sel_b    = w_gnt_id ? req1_b  : req0_b;

`ifdef ALU_SCHED_DIV0_EN
  assign w_div0 = (w_sel_op == OP_DIV) && (w_sel_b == 32'd0);
`else
  assign w_div0 = 1'b0;
`endif

  assign w_exec_done = (r_cnt <= 4'd1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_div0 ? ST_RESP : ST_EXEC;
      ST_EXEC: if (w_exec_done) w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_id  <= 1'b0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_err <= 1'b0;
    end else if (r_state == ST_IDLE && w_accept) begin
      r_op  <= w_sel_op;
      r_a   <= w_sel_a;
      r_b   <= w_sel_b;
      r_id  <= w_gnt_id;
      r_cnt <= op_latency(w_sel_op, 4'(SIMPLE_LAT), 4'(MULDIV_LAT));
      if (w_div0) begin
        r_hi  <= '0;
        r_lo  <= '0;
        r_err <= 1'b1;
      end
    end else if (r_state == ST_EXEC) begin
      if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_exec_done) begin
        r_hi  <= alu_result[63:32];
        r_lo  <= alu_result[31:0];
        r_err <= 1'b0;
      end
    end
  end

  assign alu_select = (r_state == ST_EXEC) ? r_op : 4'd0;
  assign alu_value1 = (r_state == ST_EXEC) ? r_a  : 32'd0;
  assign alu_value2 = (r_state == ST_EXEC) ? r_b  : 32'd0;
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_id     = r_id;
  assign rsp_hi     = r_hi;
  assign rsp_lo     = r_lo;
  assign rsp_err    = r_err;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
- REQ-001: Parameter SIMPLE_LAT, default 1: execute cycles for opcodes 1-10; legal range 1-15.
- REQ-002: Parameter MULDIV_LAT, default 4: execute cycles for opcodes 11 (div) and 12 (mul); legal range 1-15.
- REQ-003: clock  in  1  sole clock; all state on rising edge.
- REQ-004: clear  in  1  reset, synchronous, active-high.
- REQ-005: req0_valid / req1_valid  in  1 each  requester n presents an operation.
- REQ-006: req0_ready / req1_ready  out  1 each  grant; the request is accepted on the cycle valid&ready.
- REQ-007: req0_op / req1_op  in  4 each  ALU select code (1 add ... 12 mul).
- REQ-008: req0_a, req0_b, req1_a, req1_b  in  32 each  operands.
- REQ-009: alu_value1, alu_value2  out  32 each; alu_select  out  4  drive to the shared ALU.
- REQ-010: alu_result  in  64  ALU output; div: low = quotient, high = remainder; mul: low/high product halves.
- REQ-011: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1 (originating requester); rsp_hi, rsp_lo  out  32 each; rsp_err  out  1.
- REQ-012: busy  out  1  high in any state other than IDLE.

Function
- REQ-013: FSM states: IDLE, EXEC, RESP; only one operation is in flight at a time.
- REQ-014: IDLE: at most one readyn is high, combinationally, for the arbiter winner; all readyn are low in EXEC and RESP.
- REQ-015: Two-way round-robin arbitration: if both valid, the requester named by the pointer wins; if one valid, it wins; after each grant the pointer selects the other requester.
- REQ-016: On grant (cycle T): latch op, a, b and id; next state EXEC; counter loaded with the latency for that op (opcodes 0, 13-15 use SIMPLE_LAT).
- REQ-017: EXEC: alu_value1/2/select are driven from the latched registers and held stable; in IDLE and RESP alu_select is 0.
- REQ-018: EXEC lasts exactly LAT cycles (T+1..T+LAT); alu_result is captured into rsp_hi/rsp_lo at the end of cycle T+LAT; rsp_valid rises in cycle T+LAT+1.
- REQ-019: RESP: rsp_valid, rsp_id, rsp_hi, rsp_lo and rsp_err are held until rsp_valid&rsp_ready; that cycle returns to IDLE. A new grant is possible in the next cycle, never in the same cycle.
- REQ-020: Opcodes 0 and 13-15 are dispatched normally; the result is whatever the ALU returns (zero).
- REQ-021: A requester that deasserts valid while not granted loses no state; the pointer does not change without a grant.

Reset
- REQ-022: While clear is high: state IDLE, pointer 0, counter 0, readyn 0, rsp_valid 0, rsp_id 0, rsp_hi/rsp_lo 0, rsp_err 0, alu_value1/2 0, alu_select 0, busy 0.
- REQ-023: clear asserted during EXEC or RESP aborts the operation; no response is ever produced for it.

Configuration
- REQ-024: Macro ALU_SCHED_DIV0_EN defined: a granted op 11 with b == 0 skips EXEC; the next cycle is RESP with rsp_hi = rsp_lo = 0, rsp_err = 1, and alu_select stays 0.
- REQ-025: ALU_SCHED_DIV0_EN undefined: rsp_err is constant 0; divide-by-zero is dispatched like any op 11.

Structure
- REQ-026: Shared package alu_sched_pkg holds: opcode constants OP_ADD=1 ... OP_DIV=11, OP_MUL=12; the FSM state enum; the default latency constants.
- REQ-027: The two-way round-robin arbiter is sub-module rr_arb2 (inputs req[1:0], advance; output grant[1:0]; internal pointer).

Verification
- REQ-028: req0 op 1, a=5, b=7, rsp_ready=1 → ALU sees select 1 in T+1; rsp_valid at T+2 with rsp_lo=12, rsp_hi=0, rsp_id=0.
- REQ-029: Both valid after clear (op 2, 9-4, and op 3) → req0 granted first; req1 granted on the first IDLE cycle after the req0 response completes; the next simultaneous pair goes to req0 again.
- REQ-030: req1 op 12, a=0x10000, b=0x10000 → EXEC 4 cycles; rsp_hi=1, rsp_lo=0 at T+5.
- REQ-031: op 11, a=17, b=5, rsp_ready held low 3 cycles → rsp_lo=3, rsp_hi=2 held stable until ready; busy high throughout.
- REQ-032: clear pulsed mid-EXEC of op 12 → all outputs return to reset values next cycle; no rsp_valid follows.
- REQ-033: With ALU_SCHED_DIV0_EN defined: op 11, b=0 → rsp_valid at T+1 with rsp_err=1, rsp_hi/rsp_lo=0; without it, rsp_err=0 at T+5.
